gate_share_arbiter: RTL and testbench

//  Shares one registered 2-operand logic-gate unit (AND/OR/XOR/NAND) among N_REQ requesters.

---
 rtl/gate_share_arbiter_pkg.sv | 15 +
 rtl/gate_share_arbiter_if.sv | 25 ++
 rtl/gate_share_arbiter_gate_eval_unit.sv | 24 ++
 rtl/gate_share_arbiter.sv | 133 +++++++++++++
 tb/tb_gate_share_arbiter.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/gate_share_arbiter_pkg.sv
// rtl/gate_share_arbiter_pkg.sv - opcodes and FSM state encoding for the shared gate arbiter
package gate_share_arbiter_pkg;

   localparam logic [1:0] OP_AND  = 2'b00;
   localparam logic [1:0] OP_OR   = 2'b01;
   localparam logic [1:0] OP_XOR  = 2'b10;
   localparam logic [1:0] OP_NAND = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EVAL = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/gate_share_arbiter_if.sv
// rtl/gate_share_arbiter_if.sv - requester-side bus of the shared gate arbiter
interface gate_share_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int W     = 1
);
   logic [N_REQ-1:0]   req;
   logic [N_REQ*W-1:0] op_a;
   logic [N_REQ*W-1:0] op_b;
   logic [N_REQ*2-1:0] op_sel;
   logic [N_REQ-1:0]   gnt;
   logic [W-1:0]       result;
   logic [N_REQ-1:0]   done;
   logic               busy;
   logic [7:0]         op_count;

   modport master (
      output req, op_a, op_b, op_sel,
      input  gnt, result, done, busy, op_count
   );

   modport slave (
      input  req, op_a, op_b, op_sel,
      output gnt, result, done, busy, op_count
   );
endinterface

// File: rtl/gate_share_arbiter_gate_eval_unit.sv
// rtl/gate_share_arbiter_gate_eval_unit.sv - combinational bitwise AND/OR/XOR/NAND selected by a 2-bit opcode
module gate_eval_unit
   import gate_share_arbiter_pkg::*;
#(
   parameter int W = 1
) (
   input  logic [1:0]   sel_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] y_o
);

   always_comb begin
      y_o = '0;
      case (sel_i)
         OP_AND:  y_o = a_i & b_i;
         OP_OR:   y_o = a_i | b_i;
         OP_XOR:  y_o = a_i ^ b_i;
         OP_NAND: y_o = ~(a_i & b_i);
         default: y_o = '0;
      endcase
   end

endmodule

// File: rtl/gate_share_arbiter.sv
// rtl/gate_share_arbiter.sv - round-robin sharing of one registered gate unit among N_REQ requesters
module gate_share_arbiter
   import gate_share_arbiter_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int W     = 1
) (
   input  logic               clk,
   input  logic               rst,
   gate_share_arbiter_if.slave bus
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   state_e             state_q, state_d;
   logic [N_REQ-1:0]   gnt_q, gnt_d;
   logic [N_REQ-1:0]   done_q, done_d;
   logic [W-1:0]       result_q, result_d;
   logic               busy_q, busy_d;
   logic [7:0]         op_count_q, op_count_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]   win_q, win_d;
   logic [W-1:0]       a_q, a_d;
   logic [W-1:0]       b_q, b_d;
   logic [1:0]         sel_q, sel_d;

   logic               win_found;
   logic [IDX_W-1:0]   win_idx;
   logic [IDX_W-1:0]   cand;
   logic [W-1:0]       gate_y;

   // Search starts at rr_ptr and wraps; first requester found wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = IDX_W'((int'(rr_ptr_q) + i) % N_REQ);
         if (!win_found && bus.req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   gate_eval_unit #(.W(W)) u_gate (
      .sel_i (sel_q),
      .a_i   (a_q),
      .b_i   (b_q),
      .y_o   (gate_y)
   );

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      done_d     = done_q;
      result_d   = result_q;
      busy_d     = busy_q;
      op_count_d = op_count_q;
      rr_ptr_d   = rr_ptr_q;
      win_d      = win_q;
      a_d        = a_q;
      b_d        = b_q;
      sel_d      = sel_q;
      case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               gnt_d   = N_REQ'(1) << win_idx;
               busy_d  = 1'b1;
               win_d   = win_idx;
               a_d     = bus.op_a[int'(win_idx)*W +: W];
               b_d     = bus.op_b[int'(win_idx)*W +: W];
               sel_d   = bus.op_sel[int'(win_idx)*2 +: 2];
               state_d = ST_EVAL;
            end
         end
         ST_EVAL: begin
            result_d = gate_y;
            done_d   = gnt_q;
            state_d  = ST_DONE;
         end
         ST_DONE: begin
            done_d     = '0;
            gnt_d      = '0;
            busy_d     = 1'b0;
            op_count_d = op_count_q + 8'd1;
            rr_ptr_d   = (win_q == IDX_W'(N_REQ - 1)) ? '0 : win_q + IDX_W'(1);
            state_d    = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            done_d  = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         gnt_q      <= '0;
         done_q     <= '0;
         result_q   <= '0;
         busy_q     <= 1'b0;
         op_count_q <= '0;
         rr_ptr_q   <= '0;
         win_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         sel_q      <= '0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         done_q     <= done_d;
         result_q   <= result_d;
         busy_q     <= busy_d;
         op_count_q <= op_count_d;
         rr_ptr_q   <= rr_ptr_d;
         win_q      <= win_d;
         a_q        <= a_d;
         b_q        <= b_d;
         sel_q      <= sel_d;
      end
   end

   assign bus.gnt      = gnt_q;
   assign bus.done     = done_q;
   assign bus.result   = result_q;
   assign bus.busy     = busy_q;
   assign bus.op_count = op_count_q;

endmodule

// File: tb/tb_gate_share_arbiter.sv
// tb/tb_gate_share_arbiter.sv - directed, table-driven self-checking bench for gate_share_arbiter
module tb_gate_share_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   gate_share_arbiter_if #(.N_REQ(4), .W(1)) bus ();

   gate_share_arbiter #(.N_REQ(4), .W(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       a;
      logic       b;
      logic [1:0] sel;
      logic       exp;
   } vec_t;

   vec_t vecs[16];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.req = '0;
      step();
      step();
      rst = 1'b0;
   endtask

   // Other slots carry inverted operands so a packing slip changes the result.
   task automatic load_ops(input int k, input logic a, input logic b, input logic [1:0] sel);
      logic [3:0] va, vb;
      logic [7:0] vs;
      va = {4{~a}};
      vb = {4{~b}};
      vs = {4{~sel}};
      va[k] = a;
      vb[k] = b;
      vs[k*2 +: 2] = sel;
      bus.op_a = va;
      bus.op_b = vb;
      bus.op_sel = vs;
   endtask

   task automatic run_op(input int k, input logic a, input logic b, input logic [1:0] sel,
                         input logic exp);
      logic [3:0] oh;
      oh = 4'b0001 << k;
      load_ops(k, a, b, sel);
      bus.req = oh;
      step();
      check("op_gnt", 32'(bus.gnt), 32'(oh));
      check("op_busy", 32'(bus.busy), 32'd1);
      bus.req = '0;
      step();
      check("op_done", 32'(bus.done), 32'(oh));
      check("op_result", 32'(bus.result), 32'(exp));
      step();
      check("op_idle_done", 32'(bus.done), 32'd0);
      check("op_idle_gnt", 32'(bus.gnt), 32'd0);
   endtask

   initial begin
      logic [7:0] nb;
      logic a0, b0;

      vecs[0]  = '{1'b0, 1'b0, 2'b00, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 2'b00, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 2'b00, 1'b0};
      vecs[3]  = '{1'b1, 1'b1, 2'b00, 1'b1};
      vecs[4]  = '{1'b0, 1'b0, 2'b01, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 2'b01, 1'b1};
      vecs[6]  = '{1'b1, 1'b0, 2'b01, 1'b1};
      vecs[7]  = '{1'b1, 1'b1, 2'b01, 1'b1};
      vecs[8]  = '{1'b0, 1'b0, 2'b10, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 2'b10, 1'b1};
      vecs[10] = '{1'b1, 1'b0, 2'b10, 1'b1};
      vecs[11] = '{1'b1, 1'b1, 2'b10, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 2'b11, 1'b1};
      vecs[13] = '{1'b0, 1'b1, 2'b11, 1'b1};
      vecs[14] = '{1'b1, 1'b0, 2'b11, 1'b1};
      vecs[15] = '{1'b1, 1'b1, 2'b11, 1'b0};

      bus.req = '0;
      bus.op_a = '0;
      bus.op_b = '0;
      bus.op_sel = '0;

      // Reset state and first transaction latency
      do_reset();
      check("rst_gnt", 32'(bus.gnt), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_result", 32'(bus.result), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_count", 32'(bus.op_count), 32'd0);
      load_ops(0, 1'b1, 1'b1, 2'b00);
      bus.req = 4'b0001;
      step();
      check("t1_gnt", 32'(bus.gnt), 32'h1);
      check("t1_done_early", 32'(bus.done), 32'd0);
      bus.req = '0;
      step();
      check("t1_done", 32'(bus.done), 32'h1);
      check("t1_result", 32'(bus.result), 32'd1);
      step();
      check("t1_busy", 32'(bus.busy), 32'd0);
      check("t1_count", 32'(bus.op_count), 32'd1);

      // Truth tables, spread over all requester slots
      for (int i = 0; i < 16; i++)
         run_op((i * 3) % 4, vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].exp);
      check("tt_count", 32'(bus.op_count), 32'd17);

      // All requesting: strict rotation, done every third cycle
      do_reset();
      bus.op_a = 4'b1111;
      bus.op_b = 4'b0000;
      bus.op_sel = 8'b01010101;
      bus.req = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         step();
         check("rot_gnt", 32'(bus.gnt), 32'(4'b0001 << (g % 4)));
         step();
         check("rot_done", 32'(bus.done), 32'(4'b0001 << (g % 4)));
         check("rot_result", 32'(bus.result), 32'd1);
         step();
         check("rot_gap", 32'(bus.done), 32'd0);
         check("rot_count", 32'(bus.op_count), 32'(g + 1));
      end
      bus.req = '0;
      step();

      // Wrap of the round-robin pointer after serving req1
      do_reset();
      run_op(1, 1'b1, 1'b0, 2'b01, 1'b1);
      load_ops(0, 1'b0, 1'b1, 2'b10);
      bus.req = 4'b0011;
      step();
      check("wrap_gnt0", 32'(bus.gnt), 32'h1);
      bus.req = 4'b0010;
      step();
      check("wrap_done0", 32'(bus.done), 32'h1);
      check("wrap_res0", 32'(bus.result), 32'd1);
      step();
      step();
      check("wrap_gnt1", 32'(bus.gnt), 32'h2);
      bus.req = '0;
      step();
      check("wrap_done1", 32'(bus.done), 32'h2);
      step();

      // Reset during EVAL aborts the operation and restores req0 priority
      do_reset();
      run_op(1, 1'b0, 1'b0, 2'b11, 1'b1);
      load_ops(2, 1'b1, 1'b1, 2'b00);
      bus.req = 4'b0100;
      step();
      check("abort_gnt", 32'(bus.gnt), 32'h4);
      rst = 1'b1;
      bus.req = '0;
      step();
      rst = 1'b0;
      check("abort_done", 32'(bus.done), 32'd0);
      check("abort_gnt_clr", 32'(bus.gnt), 32'd0);
      check("abort_result", 32'(bus.result), 32'd0);
      check("abort_count", 32'(bus.op_count), 32'd0);
      step();
      check("abort_no_done", 32'(bus.done), 32'd0);
      bus.req = 4'b0110;
      step();
      check("abort_prio", 32'(bus.gnt), 32'h2);
      bus.req = '0;
      step();
      step();

      // 256 completions with operand changes during EVAL
      do_reset();
      bus.req = 4'b0001;
      for (int n = 0; n < 256; n++) begin
         nb = 8'(n);
         a0 = nb[0];
         b0 = nb[1];
         load_ops(0, a0, b0, 2'b10);
         step();
         load_ops(0, ~a0, b0, 2'b00);
         step();
         check("wrap_xor", 32'(bus.result), 32'(a0 ^ b0));
         step();
         if (n == 254) check("count_255", 32'(bus.op_count), 32'd255);
         if (n == 255) check("count_wrap", 32'(bus.op_count), 32'd0);
      end
      bus.req = '0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   always @(negedge clk) begin
      if (!rst) begin
         n_checks++;
         if (!$onehot0(bus.gnt) || !$onehot0(bus.done) ||
             ((bus.done != '0) && (bus.gnt != bus.done))) begin
            n_fail++;
            $display("FAIL invariant: gnt=%b done=%b", bus.gnt, bus.done);
         end
      end
   end

endmodule
